// File: rtl/burst_read_scheduler_pkg.sv
// Shared types for the burst read scheduler: FSM state encoding and a width helper.
package burst_read_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        LAUNCH,
        SETTLE,
        WAIT,
        COMPLETE
    } state_t;

    // Minimum of 1 so a single-bit grant_id exists even for tiny configurations.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/burst_read_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping.
module burst_read_scheduler_rr_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned REQ_ID_WIDTH = 1
) (
    input  logic [NUM_REQ-1:0]      req,
    input  logic [REQ_ID_WIDTH-1:0] rr_ptr,
    output logic [REQ_ID_WIDTH-1:0] grant,
    output logic                    grant_valid
);

    localparam logic [REQ_ID_WIDTH:0] NREQ = (REQ_ID_WIDTH + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0]  rot;
    logic [REQ_ID_WIDTH:0] sum;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        sum         = '0;
        // Rotate so bit 0 is the requester at rr_ptr; the doubled vector provides the wrap.
        rot = NUM_REQ'({req, req} >> rr_ptr);
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && rot[k]) begin
                grant_valid = 1'b1;
                sum = {1'b0, rr_ptr} + (REQ_ID_WIDTH + 1)'(k);
                if (sum >= NREQ) sum = sum - NREQ;
                grant = sum[REQ_ID_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/burst_read_scheduler.sv
// Round-robin scheduler sharing one burst read master; splits transfers at
// CHUNK_BYTES-aligned boundaries and reports the owning requester on grant_id.
module burst_read_scheduler
    import burst_read_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned REQ_ID_WIDTH    = clog2(NUM_REQ),
    parameter int unsigned ADDRESSWIDTH    = 32,
    parameter int unsigned BYTEENABLEWIDTH = 2,
    parameter int unsigned CHUNK_BYTES     = 4096
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_base,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_length,
    input  logic [NUM_REQ-1:0]              req_fixed,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [REQ_ID_WIDTH-1:0]         grant_id,
    output logic                            busy,
    output logic                            ctrl_go,
    output logic [ADDRESSWIDTH-1:0]         ctrl_base,
    output logic [ADDRESSWIDTH-1:0]         ctrl_length,
    output logic                            ctrl_fixed,
    input  logic                            ctrl_done
);

    localparam logic [ADDRESSWIDTH-1:0] CHUNK     = ADDRESSWIDTH'(CHUNK_BYTES);
    localparam logic [ADDRESSWIDTH-1:0] OFF_MASK  = ADDRESSWIDTH'(CHUNK_BYTES - 1);
    localparam logic [ADDRESSWIDTH-1:0] WORD_MASK = ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);
    localparam logic [REQ_ID_WIDTH-1:0] LAST_ID   = REQ_ID_WIDTH'(NUM_REQ - 1);

    state_t                    state;
    logic [ADDRESSWIDTH-1:0]   cur_addr;
    logic [ADDRESSWIDTH-1:0]   remaining;
    logic                      cur_fixed;
    logic [ADDRESSWIDTH-1:0]   chunk_len;
    logic [REQ_ID_WIDTH-1:0]   rr_ptr;

    logic [REQ_ID_WIDTH-1:0]   arb_grant;
    logic                      arb_valid;
    logic [ADDRESSWIDTH-1:0]   sel_base;
    logic [ADDRESSWIDTH-1:0]   sel_len;
    logic                      sel_fixed;
    logic [ADDRESSWIDTH-1:0]   room;
    logic [ADDRESSWIDTH-1:0]   calc_len;

    burst_read_scheduler_rr_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .REQ_ID_WIDTH (REQ_ID_WIDTH)
    ) u_arb (
        .req         (req_valid),
        .rr_ptr      (rr_ptr),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    always_comb begin
        sel_base  = '0;
        sel_len   = '0;
        sel_fixed = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant == REQ_ID_WIDTH'(i)) begin
                sel_base  = req_base[i*ADDRESSWIDTH +: ADDRESSWIDTH];
                sel_len   = req_length[i*ADDRESSWIDTH +: ADDRESSWIDTH];
                sel_fixed = req_fixed[i];
            end
        end
        room     = cur_fixed ? CHUNK : CHUNK - (cur_addr & OFF_MASK);
        calc_len = (remaining < room) ? remaining : room;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_ack     <= '0;
            req_done    <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            ctrl_go     <= 1'b0;
            ctrl_base   <= '0;
            ctrl_length <= '0;
            ctrl_fixed  <= 1'b0;
            cur_addr    <= '0;
            remaining   <= '0;
            cur_fixed   <= 1'b0;
            chunk_len   <= '0;
            rr_ptr      <= '0;
        end else begin
            req_ack  <= '0;
            req_done <= '0;
            ctrl_go  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        req_ack   <= NUM_REQ'(1) << arb_grant;
                        grant_id  <= arb_grant;
                        cur_addr  <= sel_base;
                        remaining <= sel_len & WORD_MASK;
                        cur_fixed <= sel_fixed;
                        rr_ptr    <= (arb_grant == LAST_ID) ? '0 : arb_grant + REQ_ID_WIDTH'(1);
                        busy      <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (remaining == '0) begin
                        state <= COMPLETE;
                    end else begin
                        chunk_len   <= calc_len;
                        ctrl_go     <= 1'b1;
                        ctrl_base   <= cur_addr;
                        ctrl_length <= calc_len;
                        ctrl_fixed  <= cur_fixed;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: state <= SETTLE;
                // The master's done flag still reflects its idle state until the go edge lands.
                SETTLE: state <= WAIT;
                WAIT: begin
                    if (ctrl_done) begin
                        remaining <= remaining - chunk_len;
                        if (!cur_fixed) cur_addr <= cur_addr + chunk_len;
                        state <= CALC;
                    end
                end
                COMPLETE: begin
                    req_done <= NUM_REQ'(1) << grant_id;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_read_scheduler.sv
// Self-checking bench: random and directed descriptors against a chunk-list reference model.
module tb_burst_read_scheduler;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int BE = 2;
    localparam int CB = 4096;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_base;
    logic [NR*AW-1:0]  req_length;
    logic [NR-1:0]     req_fixed;
    logic [NR-1:0]     req_ack;
    logic [NR-1:0]     req_done;
    logic [0:0]        grant_id;
    logic              busy;
    logic              ctrl_go;
    logic [AW-1:0]     ctrl_base;
    logic [AW-1:0]     ctrl_length;
    logic              ctrl_fixed;
    logic              ctrl_done = 1'b1;

    burst_read_scheduler #(
        .NUM_REQ         (NR),
        .REQ_ID_WIDTH    (1),
        .ADDRESSWIDTH    (AW),
        .BYTEENABLEWIDTH (BE),
        .CHUNK_BYTES     (CB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_base    (req_base),
        .req_length  (req_length),
        .req_fixed   (req_fixed),
        .req_ack     (req_ack),
        .req_done    (req_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .ctrl_go     (ctrl_go),
        .ctrl_base   (ctrl_base),
        .ctrl_length (ctrl_length),
        .ctrl_fixed  (ctrl_fixed),
        .ctrl_done   (ctrl_done)
    );

    typedef struct {
        logic [31:0] base;
        logic [31:0] len;
        logic        fixed;
        int          id;
    } chunk_t;

    chunk_t go_q[$];
    chunk_t exp_q[$];
    int     ack_q[$], ack_cyc[$], done_q[$], done_cyc[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     last_id = NR - 1;
    bit     hang = 0;
    int     m_st = 0;
    int     m_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Event recorder.
    always @(negedge clk) begin
        if (!reset) begin
            if (ctrl_go) go_q.push_back('{ctrl_base, ctrl_length, ctrl_fixed, int'(grant_id)});
            for (int i = 0; i < NR; i++) begin
                if (req_ack[i]) begin ack_q.push_back(i); ack_cyc.push_back(cyc); end
                if (req_done[i]) begin done_q.push_back(i); done_cyc.push_back(cyc); end
            end
            if (|req_ack) begin
                checks++;
                if ((req_ack & req_done) != '0) begin
                    errors++;
                    $display("FAIL ack_done_overlap: ack=%b done=%b required disjoint", req_ack, req_done);
                end
            end
        end
    end

    // Master model: done stays high through the cycle after go, then busy for a random time.
    always @(negedge clk) begin
        if (reset) begin
            m_st = 0;
            ctrl_done = 1'b1;
        end else if (ctrl_go) begin
            checks++;
            if (m_st != 0) begin
                errors++;
                $display("FAIL go_while_busy: ctrl_go=1 with master state %0d, required idle master", m_st);
            end
            m_st = 1;
        end else if (m_st == 1) begin
            ctrl_done = 1'b1;
            m_cnt = $urandom_range(0, 3);
            m_st = 2;
        end else if (m_st == 2) begin
            if (hang) ctrl_done = 1'b0;
            else if (m_cnt == 0) begin ctrl_done = 1'b1; m_st = 0; end
            else begin ctrl_done = 1'b0; m_cnt--; end
        end
        if (!reset && |req_done) begin
            checks++;
            if (m_st != 0) begin
                errors++;
                $display("FAIL done_early: req_done=%b while master state %0d, required master idle", req_done, m_st);
            end
        end
    end

    function automatic void build(input logic [31:0] base, input logic [31:0] len,
                                  input logic fixed, input int id);
        logic [31:0] addr;
        longint rem, room, c;
        exp_q.delete();
        addr = base;
        rem  = longint'(len) - longint'(len) % BE;
        while (rem > 0) begin
            room = fixed ? CB : CB - longint'(addr % CB);
            c    = (rem < room) ? rem : room;
            exp_q.push_back('{addr, 32'(c), fixed, id});
            rem -= c;
            if (!fixed) addr += 32'(c);
        end
    endfunction

    task automatic clear_q();
        go_q.delete(); ack_q.delete(); ack_cyc.delete(); done_q.delete(); done_cyc.delete();
    endtask

    task automatic do_req(input int idx, input logic [31:0] base, input logic [31:0] len,
                          input logic fixed, output bit to);
        bit got;
        to = 0;
        clear_q();
        req_base[idx*AW +: AW]   = base;
        req_length[idx*AW +: AW] = len;
        req_fixed[idx]           = fixed;
        req_valid[idx]           = 1'b1;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (req_ack[idx]) got = 1;
        end
        req_valid[idx] = 1'b0;
        if (!got) to = 1;
        got = 0;
        for (int k = 0; k < 5000 && !got && !to; k++) begin
            @(negedge clk);
            if (req_done[idx]) got = 1;
        end
        if (!got) to = 1;
        last_id = idx;
        #1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, ctrl_go, ctrl_fixed, req_ack, req_done, grant_id, ctrl_base, ctrl_length} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b go=%b ack=%b done=%b gid=%b base=%h len=%h, required all 0",
                     busy, ctrl_go, req_ack, req_done, grant_id, ctrl_base, ctrl_length);
        end
        req_valid = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b required 0", busy);
        end
    endtask

    task automatic test_directed();
        int          t_id[3]    = '{0, 1, 0};
        logic [31:0] t_base[3]  = '{32'h1000, 32'h0F80, 32'h40};
        logic [31:0] t_len[3]   = '{32'h100, 32'h200, 32'h2004};
        logic        t_fix[3]   = '{1'b0, 1'b0, 1'b1};
        bit to;
        for (int t = 0; t < 3; t++) begin
            build(t_base[t], t_len[t], t_fix[t], t_id[t]);
            do_req(t_id[t], t_base[t], t_len[t], t_fix[t], to);
            checks++;
            if (to) begin errors++; $display("FAIL directed%0d_timeout: no ack/done, required both", t); end
            checks++;
            if (go_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL directed%0d_chunks: got %0d required %0d", t, go_q.size(), exp_q.size());
            end
            for (int i = 0; i < go_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (go_q[i].base !== exp_q[i].base || go_q[i].len !== exp_q[i].len ||
                    go_q[i].fixed !== exp_q[i].fixed || go_q[i].id != exp_q[i].id) begin
                    errors++;
                    $display("FAIL directed%0d_chunk%0d: got base=%h len=%h fixed=%b id=%0d required base=%h len=%h fixed=%b id=%0d",
                             t, i, go_q[i].base, go_q[i].len, go_q[i].fixed, go_q[i].id,
                             exp_q[i].base, exp_q[i].len, exp_q[i].fixed, exp_q[i].id);
                end
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || ack_q.size() != 1 || ack_q[0] != t_id[t]) begin
                errors++;
                $display("FAIL directed%0d_status: busy=%b acks=%0d required busy 0 with one ack to %0d",
                         t, busy, ack_q.size(), t_id[t]);
            end
        end
    endtask

    task automatic test_zero_length();
        bit to;
        for (int l = 0; l < 2; l++) begin
            do_req(1, 32'h2000, 32'(l), 1'b0, to);
            checks++;
            if (to || go_q.size() != 0) begin
                errors++;
                $display("FAIL zero_len%0d_go: timeout=%0d go_count=%0d required 0/0", l, to, go_q.size());
            end
            checks++;
            if (to || ack_cyc.size() != 1 || done_cyc.size() != 1 || done_cyc[0] - ack_cyc[0] != 2) begin
                errors++;
                $display("FAIL zero_len%0d_latency: acks=%0d dones=%0d required done 2 cycles after ack",
                         l, ack_cyc.size(), done_cyc.size());
            end
        end
    endtask

    task automatic test_contention();
        int n_ack, n_done, first;
        first = (last_id + 1) % NR;
        clear_q();
        for (int i = 0; i < NR; i++) begin
            req_base[i*AW +: AW]   = 32'h8000 + 32'(i) * 32'h100;
            req_length[i*AW +: AW] = 32'h4;
        end
        req_fixed = '0;
        req_valid = '1;
        n_ack = 0;
        for (int k = 0; k < 200 && n_ack < 4; k++) begin
            @(negedge clk);
            if (|req_ack) n_ack++;
        end
        req_valid = '0;
        n_done = 0;
        for (int k = 0; k < 200 && n_done < 4; k++) begin
            @(negedge clk);
            if (|req_done) n_done++;
        end
        #1;
        checks++;
        if (ack_q.size() != 4 || done_q.size() != 4 || go_q.size() != 4) begin
            errors++;
            $display("FAIL contention_counts: acks=%0d dones=%0d gos=%0d required 4/4/4",
                     ack_q.size(), done_q.size(), go_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ack_q[k] != (first + k) % NR || done_q[k] != ack_q[k] || go_q[k].id != ack_q[k]) begin
                    errors++;
                    $display("FAIL contention_order%0d: ack=%0d done=%0d go_id=%0d required %0d",
                             k, ack_q[k], done_q[k], go_q[k].id, (first + k) % NR);
                end
                if (k < 3) begin
                    checks++;
                    if (ack_cyc[k+1] <= done_cyc[k]) begin
                        errors++;
                        $display("FAIL contention_gap%0d: next ack cycle %0d required after done cycle %0d",
                                 k, ack_cyc[k+1], done_cyc[k]);
                    end
                end
            end
            last_id = ack_q[3];
        end
    endtask

    task automatic test_reset_in_wait();
        bit got, to;
        hang = 1;
        clear_q();
        req_base[0 +: AW] = 32'h2000;
        req_length[0 +: AW] = 32'h80;
        req_fixed[0] = 1'b0;
        req_valid[0] = 1'b1;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (ctrl_go) got = 1;
            if (req_ack[0]) req_valid[0] = 1'b0;
        end
        req_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (!got || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_entry: go_seen=%0d busy=%b required 1/1", got, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, ctrl_go, ctrl_fixed, req_ack, req_done, grant_id, ctrl_base, ctrl_length} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b go=%b ack=%b done=%b base=%h len=%h required all 0",
                     busy, ctrl_go, req_ack, req_done, ctrl_base, ctrl_length);
        end
        repeat (2) @(negedge clk);
        hang = 0;
        reset = 1'b0;
        last_id = NR - 1;
        repeat (3) @(negedge clk);
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_done: dones=%0d required 0", done_q.size());
        end
        build(32'h3000, 32'h10, 1'b0, 1);
        do_req(1, 32'h3000, 32'h10, 1'b0, to);
        checks++;
        if (to || go_q.size() != 1 || go_q[0].base !== exp_q[0].base || go_q[0].len !== exp_q[0].len) begin
            errors++;
            $display("FAIL post_reset_req: timeout=%0d gos=%0d required one chunk base=%h len=%h",
                     to, go_q.size(), exp_q[0].base, exp_q[0].len);
        end
    endtask

    task automatic test_random();
        bit to;
        int idx;
        logic [31:0] base, len;
        logic fixed;
        for (int t = 0; t < 24; t++) begin
            idx   = $urandom_range(0, NR - 1);
            base  = $urandom & 32'h0000_7FFE;
            if ($urandom_range(0, 1) == 1) base = 32'h1000 * $urandom_range(1, 6) - 2 * $urandom_range(0, 64);
            len   = $urandom_range(0, 32'h2800);
            fixed = ($urandom_range(0, 3) == 0);
            build(base, len, fixed, idx);
            do_req(idx, base, len, fixed, to);
            checks++;
            if (to || go_q.size() != exp_q.size() || done_q.size() != 1 || done_q[0] != idx) begin
                errors++;
                $display("FAIL rand%0d_summary: timeout=%0d chunks=%0d required %0d, dones=%0d for id %0d",
                         t, to, go_q.size(), exp_q.size(), done_q.size(), idx);
            end
            for (int i = 0; i < go_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (go_q[i].base !== exp_q[i].base || go_q[i].len !== exp_q[i].len ||
                    go_q[i].fixed !== exp_q[i].fixed || go_q[i].id != exp_q[i].id) begin
                    errors++;
                    $display("FAIL rand%0d_chunk%0d: got base=%h len=%h fixed=%b id=%0d required base=%h len=%h fixed=%b id=%0d",
                             t, i, go_q[i].base, go_q[i].len, go_q[i].fixed, go_q[i].id,
                             exp_q[i].base, exp_q[i].len, exp_q[i].fixed, exp_q[i].id);
                end
            end
        end
    endtask

    initial begin
        req_valid  = '0;
        req_base   = '0;
        req_length = '0;
        req_fixed  = '0;
        test_reset();
        test_directed();
        test_zero_length();
        test_contention();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_read_scheduler.md
Name: burst_read_scheduler

Overview:
- Round-robin scheduler that shares one burst read master between NUM_REQ requesters.
- Accepts a (base, length, fixed) read descriptor from a requester and drives the master's go/base/length/fixed control port.
- Splits each transfer into chunks that never cross a CHUNK_BYTES-aligned address boundary.
- Exposes the grant ID so downstream logic can steer the master's output FIFO data to the owning requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- REQ_ID_WIDTH, 1, width of grant_id; equals clog2(NUM_REQ).
- ADDRESSWIDTH, 32, width of address and length.
- BYTEENABLEWIDTH, 2, bytes per word.
- CHUNK_BYTES, 4096, chunk size and boundary; power of 2 and a multiple of BYTEENABLEWIDTH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held until the matching req_ack.
- req_base  in  NUM_REQ*ADDRESSWIDTH  packed byte base address, word aligned.
- req_length  in  NUM_REQ*ADDRESSWIDTH  packed byte length.
- req_fixed  in  NUM_REQ  per-requester fixed-location flag.
- req_ack  out  NUM_REQ  one-cycle pulse when a descriptor is captured.
- req_done  out  NUM_REQ  one-cycle pulse when the last chunk's data has returned.
- grant_id  out  REQ_ID_WIDTH  index of the current owner.
- busy  out  1  high in any state other than IDLE.
- ctrl_go  out  1  one-cycle start pulse to the master.
- ctrl_base  out  ADDRESSWIDTH  chunk base address.
- ctrl_length  out  ADDRESSWIDTH  chunk length in bytes.
- ctrl_fixed  out  1  fixed-location flag for the chunk.
- ctrl_done  in  1  master done: length==0 and no reads pending.

Behaviour:
- Reset (asynchronous): state=IDLE; every output 0; rr_ptr=0; cur_addr, remaining, cur_fixed all 0.
- A reset mid-transfer abandons it with no req_done; the master is reset on the same reset net.
- Internal registers: cur_addr, remaining, cur_fixed, chunk_len, rr_ptr.
- Length: low log2(BYTEENABLEWIDTH) bits of req_length are dropped (truncated to whole words).
- IDLE:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward, wrapping.
  - In the same cycle: pulse req_ack[g], load grant_id=g, capture cur_addr, remaining, cur_fixed; go to CALC.
  - rr_ptr becomes g+1 mod NUM_REQ.
- CALC:
  - If remaining==0, go to COMPLETE. No ctrl_go is issued for a zero-length request.
  - Otherwise chunk_len = min(remaining, room).
  - room = CHUNK_BYTES when cur_fixed=1; otherwise CHUNK_BYTES - (cur_addr mod CHUNK_BYTES).
  - Go to LAUNCH.
- LAUNCH:
  - ctrl_go=1 for exactly one cycle; ctrl_base=cur_addr, ctrl_length=chunk_len, ctrl_fixed=cur_fixed.
  - ctrl_base/length/fixed hold stable from LAUNCH until the next LAUNCH.
  - Go to SETTLE.
- SETTLE: ctrl_done is ignored for one cycle, because the master's length register loads on the go edge. Go to WAIT.
- WAIT:
  - Stay until ctrl_done=1.
  - Then remaining -= chunk_len; cur_addr += chunk_len unless cur_fixed=1. Go to CALC.
- COMPLETE:
  - req_done[grant_id] pulses for one cycle; go to IDLE.
  - A new grant can occur no earlier than the cycle after COMPLETE.
- Arithmetic: all address/length math is ADDRESSWIDTH-wide, unsigned, modulo 2^ADDRESSWIDTH. Address wrap past the top of memory is not checked.
- Ordering guarantees:
  - Exactly one requester owns the master from req_ack until req_done.
  - Requests are never preempted mid-transfer.
  - req_ack and req_done never coincide for the same requester.
- Simultaneous requests: resolved by rr_ptr only. A requester whose valid drops before its ack is simply skipped.
- ctrl_done high while in IDLE/CALC/LAUNCH/SETTLE has no effect.

Decomposition:
- Shared package: state enum (IDLE, CALC, LAUNCH, SETTLE, WAIT, COMPLETE) and a clog2 helper for REQ_ID_WIDTH.
- Sub-module rr_arbiter: combinational, with req vector and rr_ptr in, grant index and grant-valid out.
- Chunk arithmetic and the FSM stay in the top module.

Test Plan:
- Single request, base=0x1000, length=0x100, not fixed -> one ctrl_go with base 0x1000, length 0x100; req_ack[0] then req_done[0]; busy low afterwards.
- Boundary split, base=0x0F80, length=0x200 -> chunk 1 base 0x0F80 length 0x80; chunk 2 base 0x1000 length 0x180; req_done after the second ctrl_done.
- Fixed location, base=0x40, length=0x2004, fixed=1 -> chunks of 0x1000, 0x1000, 0x4, all with base 0x40 and ctrl_fixed=1.
- Contention: both requesters valid continuously, each length 4 -> grants alternate 0,1,0,1; the second grant comes after COMPLETE; ack order matches grant_id.
- Zero length (0 or 1 with BYTEENABLEWIDTH=2) -> req_ack then req_done two cycles later; no ctrl_go.
- ctrl_done held at 1 on the cycle after ctrl_go -> ignored (SETTLE); reset asserted in WAIT -> all outputs 0 immediately, no req_done, next request handled normally.
